// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-mode codes and small
// constant helpers used by both uart_frame_tx and uart_frame_rx.
package uart_pkg;

    typedef enum logic [5:0] {
        IDLE       = 6'b000001,
        START_BIT  = 6'b000010,
        SHIFT_PRO  = 6'b000100,
        PARITY_BIT = 6'b001000,
        STOP_BIT   = 6'b010000,
        DONE       = 6'b100000
    } uart_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_ODD  = 2'b01,
        PAR_EVEN = 2'b10
    } parity_mode_t;

    // Width able to hold 0..value-1; never narrower than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << width) < value) width = i + 1;
        end
        return width;
    endfunction

    function automatic parity_mode_t parity_mode(input string name);
        if (name == "EVEN") return PAR_EVEN;
        if (name == "ODD")  return PAR_ODD;
        return PAR_NONE;
    endfunction

    // Value the parity bit must carry for the given data word.
    function automatic logic parity_expected(input parity_mode_t mode, input logic [8:0] data);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_frame_rx_if.sv
// Line side and system side of the UART frame receiver.
interface uart_frame_rx_if #(
    parameter int FRAME_WD = 8
);
    logic                uart_rx;
    logic [FRAME_WD-1:0] data_frame;
    logic                rx_done;
    logic                parity_error;
    logic                frame_error;
    logic                rx_busy;

    modport master (
        output uart_rx,
        input  data_frame, rx_done, parity_error, frame_error, rx_busy
    );

    modport slave (
        input  uart_rx,
        output data_frame, rx_done, parity_error, frame_error, rx_busy
    );
endinterface

// File: rtl/uart_frame_rx_clk_gen.sv
// Receive baud generator: one bps_sample pulse half a bit after start,
// then one every full bit until the FSM returns to idle.
module rx_clk_gen
    import uart_pkg::*;
#(
    parameter int BIT_CNT = 10
) (
    input  logic clk,
    input  logic reset_p,
    input  logic start,
    input  logic idle,
    output logic bps_sample
);

    localparam int                CNT_WD    = clog2(BIT_CNT);
    localparam logic [CNT_WD-1:0] FULL_LAST = CNT_WD'(BIT_CNT - 1);
    localparam logic [CNT_WD-1:0] HALF_LAST = CNT_WD'(BIT_CNT / 2 - 1);

    logic [CNT_WD-1:0] baud_cnt;
    logic              first_half;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset_p || start || idle) begin
            baud_cnt   <= '0;
            first_half <= 1'b1;
            bps_sample <= 1'b0;
        end else if (baud_cnt == (first_half ? HALF_LAST : FULL_LAST)) begin
            baud_cnt   <= '0;
            first_half <= 1'b0;
            bps_sample <= 1'b1;
        end else begin
            baud_cnt   <= baud_cnt + CNT_WD'(1);
            bps_sample <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// UART frame receiver: synchronises uart_rx, samples each bit mid-period,
// checks parity and stop bit, and presents the word with a rx_done strobe.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int    CLK_FREQUENCE = 125_000_000,
    parameter int    BAUD_RATE     = 9600,
    parameter string PARITY        = "NONE",
    parameter int    FRAME_WD      = 8
) (
    input logic            clk,
    input logic            reset_p,
    uart_frame_rx_if.slave rx
);

    localparam int                BIT_CNT  = CLK_FREQUENCE / BAUD_RATE;
    localparam int                BW       = clog2(FRAME_WD);
    localparam logic [BW-1:0]     LAST_BIT = BW'(FRAME_WD - 1);
    localparam parity_mode_t      PAR_MODE = parity_mode(PARITY);

    uart_state_t         state;
    logic [2:0]          sync_q;
    logic [BW-1:0]       bit_cnt;
    logic [FRAME_WD-1:0] shift_reg;
    logic                parity_sample;
    logic                stop_sample;
    logic                bps_sample;

    // sync_q[1] is the conditioned line; sync_q[2] is its previous value.
    wire line      = sync_q[1];
    wire fall_edge = sync_q[2] & ~sync_q[1];
    wire in_idle   = (state == IDLE);

    rx_clk_gen #(
        .BIT_CNT (BIT_CNT)
    ) u_clk_gen (
        .clk        (clk),
        .reset_p    (reset_p),
        .start      (in_idle && fall_edge),
        .idle       (in_idle),
        .bps_sample (bps_sample)
    );

    always_ff @(posedge clk) begin
        if (reset_p) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], rx.uart_rx};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: rx_done defaults low every cycle so it can only be a
        // single-cycle pulse, raised solely from the DONE state below.
        rx.rx_done <= 1'b0;
        if (reset_p) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            shift_reg       <= '0;
            parity_sample   <= 1'b0;
            stop_sample     <= 1'b1;
            rx.data_frame   <= '0;
            rx.parity_error <= 1'b0;
            rx.frame_error  <= 1'b0;
            rx.rx_busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fall_edge) begin
                        state      <= START_BIT;
                        rx.rx_busy <= 1'b1;
                    end
                end
                START_BIT: begin
                    if (bps_sample) begin
                        if (!line) begin
                            state   <= SHIFT_PRO;
                            bit_cnt <= '0;
                        end else begin
                            state      <= IDLE;
                            rx.rx_busy <= 1'b0;
                        end
                    end
                end
                SHIFT_PRO: begin
                    if (bps_sample) begin
                        shift_reg[bit_cnt] <= line;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= (PAR_MODE == PAR_NONE) ? STOP_BIT : PARITY_BIT;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                PARITY_BIT: begin
                    if (bps_sample) begin
                        parity_sample <= line;
                        state         <= STOP_BIT;
                    end
                end
                STOP_BIT: begin
                    if (bps_sample) begin
                        stop_sample <= line;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    rx.rx_done      <= 1'b1;
                    rx.data_frame   <= shift_reg;
                    rx.parity_error <= (PAR_MODE != PAR_NONE) &&
                                       (parity_sample != parity_expected(PAR_MODE, 9'(shift_reg)));
                    rx.frame_error  <= ~stop_sample;
                    rx.rx_busy      <= 1'b0;
                    state           <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    rx.rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: three receivers (NONE / EVEN / ODD)
// driven by a behavioural serial transmitter and checked against a frame model.
module tb_uart_frame_rx;

    localparam int BIT = 10;

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    logic reset_p = 1'b1;
    logic line [3];

    always #5 clk = ~clk;

    uart_frame_rx_if #(.FRAME_WD(8)) if_n ();
    uart_frame_rx_if #(.FRAME_WD(8)) if_e ();
    uart_frame_rx_if #(.FRAME_WD(8)) if_o ();

    assign if_n.uart_rx = line[0];
    assign if_e.uart_rx = line[1];
    assign if_o.uart_rx = line[2];

    uart_frame_rx #(.CLK_FREQUENCE(1_000_000), .BAUD_RATE(100_000), .PARITY("NONE"), .FRAME_WD(8))
        dut_n (.clk(clk), .reset_p(reset_p), .rx(if_n));
    uart_frame_rx #(.CLK_FREQUENCE(1_000_000), .BAUD_RATE(100_000), .PARITY("EVEN"), .FRAME_WD(8))
        dut_e (.clk(clk), .reset_p(reset_p), .rx(if_e));
    uart_frame_rx #(.CLK_FREQUENCE(1_000_000), .BAUD_RATE(100_000), .PARITY("ODD"), .FRAME_WD(8))
        dut_o (.clk(clk), .reset_p(reset_p), .rx(if_o));

    logic [2:0]      done_v, perr_v, ferr_v, busy_v;
    logic [2:0][7:0] dat_v;
    assign done_v = {if_o.rx_done, if_e.rx_done, if_n.rx_done};
    assign perr_v = {if_o.parity_error, if_e.parity_error, if_n.parity_error};
    assign ferr_v = {if_o.frame_error, if_e.frame_error, if_n.frame_error};
    assign busy_v = {if_o.rx_busy, if_e.rx_busy, if_n.rx_busy};
    assign dat_v  = {if_o.data_frame, if_e.data_frame, if_n.data_frame};

    int         n_checks = 0;
    int         n_errors = 0;
    exp_t       exp_q[$];
    logic [7:0] last_data [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Parity bit a well-behaved transmitter would send: k=1 EVEN, k=2 ODD.
    function automatic logic good_parity(input int k, input logic [7:0] d);
        logic odd_ones;
        odd_ones = ($countones(d) % 2) == 1;
        return (k == 2) ? !odd_ones : odd_ones;
    endfunction

    function automatic exp_t model(input int k, input logic [7:0] d, input logic pbit, input logic sbit);
        exp_t e;
        e.dut  = k;
        e.data = d;
        e.perr = (k != 0) && (pbit != good_parity(k, d));
        e.ferr = !sbit;
        return e;
    endfunction

    task automatic expect_frame(input int k, input logic [7:0] d, input logic pbit, input logic sbit);
        exp_q.push_back(model(k, d, pbit, sbit));
        last_data[k] = d;
    endtask

    task automatic drive_bit(input int k, input logic b);
        line[k] = b;
        repeat (BIT) @(posedge clk);
    endtask

    task automatic send_frame(input int k, input logic [7:0] d, input logic pbit,
                              input logic sbit, input int n_stop);
        drive_bit(k, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(k, d[i]);
        if (k != 0) drive_bit(k, pbit);
        drive_bit(k, sbit);
        for (int i = 1; i < n_stop; i++) drive_bit(k, 1'b1);
    endtask

    task automatic idle_and_drain(input int k, input string name);
        drive_bit(k, 1'b1);
        drive_bit(k, 1'b1);
        check({name, "_drain"}, exp_q.size(), 0);
        check({name, "_busy_idle"}, busy_v[k], 1'b0);
    endtask

    // Monitor: pop one expectation per rx_done pulse.
    logic [2:0] prev_done = '0;
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (done_v[k]) begin
                check("rx_done_width", prev_done[k], 1'b0);
                if (exp_q.size() == 0) begin
                    check("rx_done_unexpected", done_v[k], 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("dut_index", k, e.dut);
                    check("data_frame", dat_v[k], e.data);
                    check("parity_error", perr_v[k], e.perr);
                    check("frame_error", ferr_v[k], e.ferr);
                end
            end
        end
        prev_done = done_v;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       pb, sb;
        int         k, gap;
        logic [7:0] loop_data [3];
        loop_data[0] = 8'h00;
        loop_data[1] = 8'hFF;
        loop_data[2] = 8'h55;

        for (int i = 0; i < 3; i++) begin
            line[i]      = 1'b1;
            last_data[i] = 8'h00;
        end
        reset_p = 1'b1;
        repeat (3) @(posedge clk);
        reset_p = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_data_frame", dat_v[i], 8'h00);
            check("reset_rx_done", done_v[i], 1'b0);
            check("reset_parity_error", perr_v[i], 1'b0);
            check("reset_frame_error", ferr_v[i], 1'b0);
            check("reset_rx_busy", busy_v[i], 1'b0);
        end

        // 8N1 basic, two stop bits as uart_frame_tx sends them.
        expect_frame(0, 8'hA5, 1'b0, 1'b1);
        send_frame(0, 8'hA5, 1'b0, 1'b1, 2);
        idle_and_drain(0, "basic_8n1");

        // EVEN parity: good then bad parity bit on 0x07.
        expect_frame(1, 8'h07, 1'b1, 1'b1);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1);
        idle_and_drain(1, "even_good");
        expect_frame(1, 8'h07, 1'b0, 1'b1);
        send_frame(1, 8'h07, 1'b0, 1'b1, 1);
        idle_and_drain(1, "even_bad");

        // Framing error, then the line stays low: no re-trigger.
        expect_frame(0, 8'h3C, 1'b0, 1'b0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1);
        line[0] = 1'b0;
        repeat (30) @(posedge clk);
        check("break_busy", busy_v[0], 1'b0);
        check("break_drain", exp_q.size(), 0);
        idle_and_drain(0, "break_release");
        expect_frame(0, 8'h5A, 1'b0, 1'b1);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 2);
        idle_and_drain(0, "after_break");

        // 3-clk glitch on idle line: rejected, outputs held.
        line[0] = 1'b0;
        repeat (3) @(posedge clk);
        line[0] = 1'b1;
        repeat (30) @(posedge clk);
        check("glitch_data_held", dat_v[0], last_data[0]);
        check("glitch_frame_error_held", ferr_v[0], 1'b0);
        check("glitch_busy", busy_v[0], 1'b0);

        // Loopback-style back-to-back ODD frames.
        for (int i = 0; i < 3; i++) begin
            expect_frame(2, loop_data[i], good_parity(2, loop_data[i]), 1'b1);
            send_frame(2, loop_data[i], good_parity(2, loop_data[i]), 1'b1, 1);
        end
        idle_and_drain(2, "loopback_odd");

        // Reset during bit 4 of 0x81 aborts the frame.
        d = 8'h81;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, d[i]);
        line[0] = d[4];
        repeat (5) @(posedge clk);
        check("midframe_busy", busy_v[0], 1'b1);
        reset_p = 1'b1;
        line[0] = 1'b1;
        @(posedge clk);
        reset_p = 1'b0;
        repeat (2) @(posedge clk);
        check("abort_data_frame", dat_v[0], 8'h00);
        check("abort_parity_error", perr_v[0], 1'b0);
        check("abort_frame_error", ferr_v[0], 1'b0);
        check("abort_rx_busy", busy_v[0], 1'b0);
        repeat (20) @(posedge clk);
        check("abort_no_done", exp_q.size(), 0);
        expect_frame(0, 8'h42, 1'b0, 1'b1);
        send_frame(0, 8'h42, 1'b0, 1'b1, 2);
        idle_and_drain(0, "after_abort");

        // Randomised frames across all three parity modes.
        for (int n = 0; n < 40; n++) begin
            k  = $urandom_range(0, 2);
            d  = 8'($urandom);
            pb = good_parity(k, d) ^ ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 5) != 0);
            expect_frame(k, d, pb, sb);
            send_frame(k, d, pb, sb, (k == 0) ? 2 : 1);
            gap = sb ? $urandom_range(0, 2) : $urandom_range(1, 2);
            for (int g = 0; g < gap; g++) drive_bit(k, 1'b1);
        end
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        check("final_drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
